// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA scan-out memory path.
// Default raster geometry, fetch word packing and write-client naming.
package vga_pkg;

    localparam int H_DISPLAY      = 640;
    localparam int V_DISPLAY      = 480;
    localparam int PIX_PER_WORD   = 8;
    localparam int WORDS_PER_LINE = H_DISPLAY / PIX_PER_WORD;
    localparam int PIX_SHIFT      = $clog2(PIX_PER_WORD);

    typedef enum logic {
        CLIENT0 = 1'b0,
        CLIENT1 = 1'b1
    } client_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request round-robin arbiter with a global enable.
// The turn pointer moves only when both requests compete and one is granted.
module rr_arbiter2
    import vga_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    client_e rr_q;
    client_e rr_d;

    always_comb begin
        gnt  = 2'b00;
        rr_d = rr_q;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11: begin
                    gnt  = (rr_q == CLIENT0) ? 2'b01 : 2'b10;
                    rr_d = (rr_q == CLIENT0) ? CLIENT1 : CLIENT0;
                end
                default: gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= CLIENT0;
        end else begin
            rr_q <= rr_d;
        end
    end

endmodule

// File: rtl/vga_mem_arbiter.sv
// Single-port pixel memory scheduler: beam-locked word fetches take priority,
// remaining slots go to two write clients in round-robin order.
module vga_mem_arbiter
    import vga_pkg::*;
#(
    parameter int H_DISPLAY    = vga_pkg::H_DISPLAY,
    parameter int V_DISPLAY    = vga_pkg::V_DISPLAY,
    parameter int PIX_PER_WORD = vga_pkg::PIX_PER_WORD,
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [9:0]        hpos,
    input  logic [9:0]        vpos,
    input  logic              display_on,
    input  logic              c0_valid,
    input  logic [ADDR_W-1:0] c0_addr,
    input  logic [DATA_W-1:0] c0_data,
    output logic              c0_ready,
    input  logic              c1_valid,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic [DATA_W-1:0] c1_data,
    output logic              c1_ready,
    input  logic [1:0]        vblank_only,
    input  logic              stall_clr,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pix_word,
    output logic              pix_valid,
    output logic [7:0]        stall_cnt
);

    localparam int WORD_SHIFT = $clog2(PIX_PER_WORD);

    logic              fetch_due;
    logic              frame_start;
    logic              in_vblank;
    logic [1:0]        elig;
    logic [1:0]        gnt;
    logic              any_wait;
    logic [ADDR_W-1:0] fetch_word;

    logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
    logic              mem_en_q,     mem_en_d;
    logic              mem_we_q,     mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q,  mem_wdata_d;
    logic              rd_stage_q,   rd_stage_d;
    logic              pix_valid_q,  pix_valid_d;
    logic [DATA_W-1:0] pix_word_q,   pix_word_d;
    logic [7:0]        stall_q,      stall_d;

    assign fetch_due   = display_on && (hpos < 10'(H_DISPLAY)) && (hpos[WORD_SHIFT-1:0] == '0);
    assign frame_start = (hpos == 10'd0) && (vpos == 10'd0);
    assign in_vblank   = (vpos >= 10'(V_DISPLAY));
    assign elig[0]     = c0_valid && (!vblank_only[0] || in_vblank);
    assign elig[1]     = c1_valid && (!vblank_only[1] || in_vblank);

    // Handshake: a client write transfers in any cycle where ci_valid && ci_ready;
    // ready is purely combinational and is never raised on a fetch cycle.
    rr_arbiter2 u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (!fetch_due),
        .req   (elig),
        .gnt   (gnt)
    );

    assign c0_ready = gnt[0];
    assign c1_ready = gnt[1];
    assign any_wait = (c0_valid || c1_valid) && !(|gnt);

    always_comb begin
        fetch_word   = fetch_addr_q;
        fetch_addr_d = fetch_addr_q;
        if (fetch_due) begin
            if (frame_start) begin
                fetch_word   = '0;
                fetch_addr_d = ADDR_W'(1);
            end else begin
                fetch_addr_d = fetch_addr_q + ADDR_W'(1);
            end
        end
    end

    always_comb begin
        mem_en_d    = fetch_due || (|gnt);
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (fetch_due) begin
            mem_addr_d = fetch_word;
        end else if (gnt[0]) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = c0_addr;
            mem_wdata_d = c0_data;
        end else if (gnt[1]) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = c1_addr;
            mem_wdata_d = c1_data;
        end
    end

    // Read return tracking: strobe at t+1, RAM data at t+2, pixel word at t+3.
    always_comb begin
        rd_stage_d  = mem_en_q && !mem_we_q;
        pix_valid_d = rd_stage_q;
        pix_word_d  = rd_stage_q ? mem_rdata : pix_word_q;
    end

    always_comb begin
        stall_d = stall_q;
        if (stall_clr) begin
            stall_d = 8'd0;
        end else if (any_wait && (stall_q != 8'hFF)) begin
            stall_d = stall_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_addr_q <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rd_stage_q   <= 1'b0;
            pix_valid_q  <= 1'b0;
            pix_word_q   <= '0;
            stall_q      <= 8'd0;
        end else begin
            fetch_addr_q <= fetch_addr_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rd_stage_q   <= rd_stage_d;
            pix_valid_q  <= pix_valid_d;
            pix_word_q   <= pix_word_d;
            stall_q      <= stall_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign pix_valid = pix_valid_q;
    assign pix_word  = pix_word_q;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Self-checking bench for vga_mem_arbiter on a scaled-down raster.
// A beam/client driver feeds a reference model; a negedge monitor checks outputs.
`timescale 1ns/1ps
module tb_vga_mem_arbiter;

    localparam int HD    = 64;
    localparam int VD    = 48;
    localparam int PPW   = 8;
    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int HT    = 80;
    localparam int VT    = 56;
    localparam int FRAME = HT * VT;
    localparam int WPL   = HD / PPW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [9:0]    hpos, vpos;
    logic          display_on;
    logic          c0_valid, c1_valid;
    logic [AW-1:0] c0_addr, c1_addr;
    logic [DW-1:0] c0_data, c1_data;
    logic          c0_ready, c1_ready;
    logic [1:0]    vblank_only;
    logic          stall_clr;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata, pix_word;
    logic          pix_valid;
    logic [7:0]    stall_cnt;

    vga_mem_arbiter #(
        .H_DISPLAY(HD), .V_DISPLAY(VD), .PIX_PER_WORD(PPW), .ADDR_W(AW), .DATA_W(DW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hpos(hpos), .vpos(vpos), .display_on(display_on),
        .c0_valid(c0_valid), .c0_addr(c0_addr), .c0_data(c0_data), .c0_ready(c0_ready),
        .c1_valid(c1_valid), .c1_addr(c1_addr), .c1_data(c1_data), .c1_ready(c1_ready),
        .vblank_only(vblank_only), .stall_clr(stall_clr),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .pix_word(pix_word), .pix_valid(pix_valid), .stall_cnt(stall_cnt)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- synchronous RAM model ----------------
    logic [15:0] seed;
    logic [DW-1:0] ram [0:1023];
    bit            wr_flag [0:1023];

    function automatic logic [DW-1:0] init_val(input int a);
        return 16'(a * 40503) ^ seed;
    endfunction

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr[9:0]]     <= mem_wdata;
                wr_flag[mem_addr[9:0]] <= 1'b1;
            end else begin
                mem_rdata <= wr_flag[mem_addr[9:0]] ? ram[mem_addr[9:0]] : init_val(int'(mem_addr[9:0]));
            end
        end
    end

    // ---------------- reference model state ----------------
    logic [DW-1:0] ref_mem [0:1023];
    logic [64:0]   mem_exp_q[$];   // {cycle, we, addr, data}
    logic [63:0]   pix_exp_q[$];   // {cycle, addr, word}
    int            n_tests = 0;
    int            n_fail = 0;
    logic          exp_rdy0 = 1'b0, exp_rdy1 = 1'b0;
    logic [7:0]    exp_stall = 8'd0, stall_next = 8'd0;
    bit            turn;
    int            hcnt, vcnt;
    int            mode [2];
    bit            pend [2];
    logic [AW-1:0] req_addr [2];
    logic [DW-1:0] req_data [2];
    logic [1:0]    k_vbo;
    logic          k_clr;
    int            pix_cnt = 0;
    logic [15:0]   last_pix_addr = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_tests++;
        n_fail++;
        if (n_fail <= 40) $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [64:0] me;
    logic [63:0] pe;

    always @(negedge clk) begin
        check("c0_ready", 64'(c0_ready), 64'(exp_rdy0));
        check("c1_ready", 64'(c1_ready), 64'(exp_rdy1));
        check("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
        while (mem_exp_q.size() > 0 && int'(mem_exp_q[0][64:33]) < cyc) begin
            flag("mem_strobe_missing");
            void'(mem_exp_q.pop_front());
        end
        while (pix_exp_q.size() > 0 && int'(pix_exp_q[0][63:32]) < cyc) begin
            flag("pix_valid_missing");
            void'(pix_exp_q.pop_front());
        end
        if (mem_en) begin
            if (mem_exp_q.size() == 0) begin
                flag("mem_strobe_unexpected");
            end else begin
                me = mem_exp_q.pop_front();
                check("mem_cycle", 64'(cyc), 64'(me[64:33]));
                check("mem_we", 64'(mem_we), 64'(me[32]));
                check("mem_addr", 64'(mem_addr), 64'(me[31:16]));
                if (me[32]) check("mem_wdata", 64'(mem_wdata), 64'(me[15:0]));
            end
        end
        if (pix_valid) begin
            pix_cnt++;
            if (pix_exp_q.size() == 0) begin
                flag("pix_valid_unexpected");
            end else begin
                pe = pix_exp_q.pop_front();
                last_pix_addr = pe[31:16];
                check("pix_cycle", 64'(cyc), 64'(pe[63:32]));
                check("pix_word", 64'(pix_word), 64'(pe[15:0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_idle();
        hpos = '0; vpos = '0; display_on = 1'b0;
        c0_valid = 1'b0; c1_valid = 1'b0;
        c0_addr = '0; c1_addr = '0; c0_data = '0; c1_data = '0;
        stall_clr = 1'b0; vblank_only = k_vbo;
    endtask

    task automatic clear_model();
        mem_exp_q.delete();
        pix_exp_q.delete();
        exp_rdy0 = 1'b0; exp_rdy1 = 1'b0;
        exp_stall = 8'd0; stall_next = 8'd0;
        turn = 1'b0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        hcnt = 0; vcnt = 0;
        set_idle();
    endtask

    // One clock: drive the next beam position and client requests, predict the outcome.
    task automatic tick();
        bit fetch, vb, e0, e1, g0, g1, any;
        int a;
        @(posedge clk);
        #1;
        exp_stall = stall_next;
        if (!rst_n) begin
            set_idle();
            exp_rdy0 = 1'b0; exp_rdy1 = 1'b0;
            stall_next = 8'd0;
            return;
        end
        hpos = 10'(hcnt);
        vpos = 10'(vcnt);
        display_on = (hcnt < HD) && (vcnt < VD);
        vblank_only = k_vbo;
        stall_clr = k_clr;
        for (int i = 0; i < 2; i++) begin
            if (!pend[i] && (mode[i] == 2 || (mode[i] == 1 && $urandom_range(0, 3) == 0))) begin
                pend[i] = 1'b1;
                req_addr[i] = 16'($urandom_range(0, 1023));
                req_data[i] = 16'($urandom);
            end
        end
        c0_valid = pend[0]; c0_addr = req_addr[0]; c0_data = req_data[0];
        c1_valid = pend[1]; c1_addr = req_addr[1]; c1_data = req_data[1];

        fetch = display_on && (hcnt % PPW == 0);
        vb = (vcnt >= VD);
        e0 = pend[0] && (!k_vbo[0] || vb);
        e1 = pend[1] && (!k_vbo[1] || vb);
        any = pend[0] || pend[1];
        g0 = 1'b0; g1 = 1'b0;
        if (!fetch) begin
            if (e0 && e1) begin
                if (!turn) g0 = 1'b1; else g1 = 1'b1;
                turn = !turn;
            end else begin
                g0 = e0; g1 = e1;
            end
        end
        exp_rdy0 = g0; exp_rdy1 = g1;

        if (fetch) begin
            a = vcnt * WPL + hcnt / PPW;
            mem_exp_q.push_back({32'(cyc + 1), 1'b0, 16'(a), 16'h0});
            pix_exp_q.push_back({32'(cyc + 3), 16'(a), ref_mem[a]});
        end
        for (int i = 0; i < 2; i++) begin
            if ((i == 0 && g0) || (i == 1 && g1)) begin
                mem_exp_q.push_back({32'(cyc + 1), 1'b1, req_addr[i], req_data[i]});
                ref_mem[req_addr[i][9:0]] = req_data[i];
                pend[i] = 1'b0;
            end
        end

        if (k_clr) stall_next = 8'd0;
        else if (any && !g0 && !g1 && exp_stall != 8'd255) stall_next = exp_stall + 8'd1;
        else stall_next = exp_stall;

        hcnt++;
        if (hcnt == HT) begin
            hcnt = 0;
            vcnt = (vcnt + 1) % VT;
        end
    endtask

    task automatic run_until(input int h, input int v);
        int n = 0;
        while (!(hcnt == h && vcnt == v)) begin
            tick();
            n++;
            if (n > FRAME + 8) begin
                flag("beam_position_timeout");
                return;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_model();
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        seed = 16'($urandom);
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
        k_vbo = 2'b00; k_clr = 1'b0;
        mode[0] = 0; mode[1] = 0;
        req_addr[0] = '0; req_addr[1] = '0; req_data[0] = '0; req_data[1] = '0;
        do_reset();

        #1;
        check("rst_mem_en", 64'(mem_en), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst_pix_valid", 64'(pix_valid), 64'd0);
        check("rst_pix_word", 64'(pix_word), 64'd0);
        check("rst_stall_cnt", 64'(stall_cnt), 64'd0);

        // full frame of fetches with no client traffic
        pix_cnt = 0;
        repeat (FRAME + 4) tick();
        check("frame_pix_count", 64'(pix_cnt), 64'(WPL * VD));
        check("frame_last_addr", 64'(last_pix_addr), 64'(WPL * VD - 1));

        // collision with the fetch slot at hpos 8
        run_until(8, 5);
        mode[0] = 2;
        tick(); #1;
        check("collide_rdy_h8", 64'(c0_ready), 64'd0);
        tick(); #1;
        check("collide_rdy_h9", 64'(c0_ready), 64'd1);
        check("collide_stall", 64'(stall_cnt), 64'd1);
        mode[0] = 0;
        tick();
        pend[0] = 1'b0;

        // round robin in vblank; an odd number of ties leaves the turn on client 1
        run_until(0, VD);
        mode[0] = 2; mode[1] = 2;
        for (int k = 0; k < 4; k++) begin
            tick(); #1;
            check("rr_c0_ready", 64'(c0_ready), 64'(k % 2 == 0));
            check("rr_c1_ready", 64'(c1_ready), 64'(k % 2 == 1));
        end
        tick();
        mode[0] = 0; mode[1] = 0;
        pend[0] = 1'b0; pend[1] = 1'b0;

        // client 1 restricted to vertical blanking
        k_vbo = 2'b10;
        run_until(0, 10);
        mode[1] = 2;
        while (vcnt < VD) begin
            tick(); #1;
            check("vblank_gate", 64'(c1_ready), 64'd0);
        end
        tick(); #1;
        check("vblank_grant", 64'(c1_ready), 64'd1);
        mode[1] = 0;
        tick();
        pend[1] = 1'b0;

        // stall counter saturation and clear
        k_vbo = 2'b01;
        run_until(0, 2);
        k_clr = 1'b1; tick(); k_clr = 1'b0;
        mode[0] = 2;
        repeat (300) tick();
        #1;
        check("stall_saturate", 64'(stall_cnt), 64'd255);
        k_clr = 1'b1; tick(); k_clr = 1'b0;
        tick(); #1;
        check("stall_cleared", 64'(stall_cnt), 64'd0);

        // reset one cycle after a fetch issue, with stalls accumulated
        run_until(0, 3);
        tick();
        tick();
        do_reset();
        #1;
        check("midrst_pix_valid", 64'(pix_valid), 64'd0);
        check("midrst_mem_en", 64'(mem_en), 64'd0);
        check("midrst_stall_cnt", 64'(stall_cnt), 64'd0);
        mode[0] = 0; k_vbo = 2'b00;
        run_until(0, VD);
        mode[0] = 2; mode[1] = 2;
        tick(); #1;
        check("midrst_rr_c0", 64'(c0_ready), 64'd1);
        check("midrst_rr_c1", 64'(c1_ready), 64'd0);
        mode[0] = 0; mode[1] = 0;
        tick();
        pend[0] = 1'b0; pend[1] = 1'b0;

        // randomized traffic across two frames
        mode[0] = 1; mode[1] = 1;
        for (int n = 0; n < 2 * FRAME; n++) begin
            if (n % 500 == 0) k_vbo = 2'($urandom_range(0, 3));
            k_clr = ($urandom_range(0, 63) == 0);
            tick();
        end
        k_clr = 1'b0;
        mode[0] = 0; mode[1] = 0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        repeat (8) tick();
        #1;
        check("mem_queue_drained", 64'(mem_exp_q.size()), 64'd0);
        check("pix_queue_drained", 64'(pix_exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_mem_arbiter.md
# vga_mem_arbiter

Scheduler for the single-port pixel memory behind the VGA scan-out path. Consumes `hpos`/`vpos`/`display_on` from `hvsync_generator`. Issues hard-real-time pixel-word fetches ahead of the beam and hands the remaining memory slots to two write clients in round-robin order. Each client can optionally be restricted to vertical blanking for tear-free updates.

## Interface
Parameters:
- `H_DISPLAY`, 640: visible pixels per line.
- `V_DISPLAY`, 480: visible lines.
- `PIX_PER_WORD`, 8: pixels per memory word; power of two, 2..16.
- `ADDR_W`, 16: memory address width.
- `DATA_W`, 16: memory word width.

Ports:
- `clk`  in  1  pixel clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `hpos`, `vpos`  in  10 each  beam position from the sync generator.
- `display_on`  in  1  visible-region flag from the sync generator.
- `c0_valid`, `c1_valid`  in  1  client write request.
- `c0_addr`, `c1_addr`  in  ADDR_W  client write address.
- `c0_data`, `c1_data`  in  DATA_W  client write data.
- `c0_ready`, `c1_ready`  out  1  combinational grant; a transfer occurs when valid && ready.
- `vblank_only`  in  2  bit i set: client i is granted only while `vpos >= V_DISPLAY`.
- `stall_clr`  in  1  synchronous clear of `stall_cnt`.
- `mem_en`, `mem_we`  out  1  registered memory strobes.
- `mem_addr`  out  ADDR_W  registered memory address.
- `mem_wdata`  out  DATA_W  registered memory write data.
- `mem_rdata`  in  DATA_W  synchronous RAM read data, valid one cycle after `mem_en && !mem_we`.
- `pix_word`  out  DATA_W  fetched pixel word.
- `pix_valid`  out  1  one-cycle strobe qualifying `pix_word`.
- `stall_cnt`  out  8  saturating count of cycles with any client valid but not granted.

## Operation
- Fetch due (cycle t):
  - Condition: `display_on && hpos[log2(PIX_PER_WORD)-1:0] == 0`.
  - Fetch always wins; both readies are 0 that cycle.
- Fetch address:
  - Internal counter `fetch_addr`.
  - A fetch at `hpos==0 && vpos==0` uses address 0 and sets the counter to 1.
  - Any other fetch uses the counter value, then increments it.
  - Address is linear raster order, `H_DISPLAY/PIX_PER_WORD` words per line.
- Client eligibility: client i is eligible when `ci_valid` is high and (`vblank_only[i]==0` or `vpos >= V_DISPLAY`).
- Arbitration in non-fetch cycles:
  - One eligible client: it is granted.
  - Both eligible: grant the client indicated by the round-robin pointer `rr`, then `rr` points to the other client.
  - `rr` changes only on a two-way contention grant.
- Granted write: the next cycle drives `mem_en=1`, `mem_we=1`, `mem_addr=ci_addr`, `mem_wdata=ci_data`.
- Fetch: the next cycle drives `mem_en=1`, `mem_we=0`, `mem_addr=fetch address`.
- No grant: next cycle `mem_en=0`; address and data hold their last values.
- `stall_cnt`:
  - +1 per cycle where (`c0_valid || c1_valid`) and neither ready is high; saturates at 255.
  - `stall_clr` has priority over increment.
- Client addresses are passed through unchecked; out-of-range writes are not filtered.

## Timing
- Fetch decided at t; `mem_*` valid at t+1; `mem_rdata` at t+2; `pix_word`/`pix_valid` registered at t+3.
- Fixed fetch latency is 3 cycles; the renderer offsets by 3.
- Readies are combinational from cycle-t inputs, with no registered state other than `rr`.
- Client write commits to memory at t+1.
- Reset values:
  - All outputs 0.
  - `rr` = client 0.
  - `fetch_addr` = 0.
  - The read-tracking pipeline is cleared.
- Reset mid-operation: in-flight fetch data is dropped (`pix_valid` stays 0) and no memory strobe is issued.
- Back-to-back fetches are impossible while `PIX_PER_WORD >= 2`, so at least one client slot exists per word during visible lines.
- Simultaneous `stall_clr` and stall cycle: counter reads 0 next cycle.

## Structure
- Shared package `vga_pkg`:
  - `H_DISPLAY`, `V_DISPLAY`.
  - Derived `WORDS_PER_LINE`.
  - Localparam `PIX_SHIFT = log2(PIX_PER_WORD)`.
  - Client index enum (`CLIENT0`, `CLIENT1`).
- Sub-module `rr_arbiter2`: two requests plus enable, producing one-hot grant and owning the `rr` pointer. Everything else is flat in `vga_mem_arbiter`.

## Test plan
- Frame fetch: run one frame with no clients. Require:
  - Exactly 38400 `pix_valid` pulses.
  - First fetch `mem_addr=0` at (0,0)+1 cycle.
  - Last fetch `mem_addr=38399`.
  - `pix_word` equals the RAM model at +3.
- Collision: `c0_valid` held high at `hpos=8, vpos=5`. Require:
  - `c0_ready=0` at `hpos=8`.
  - `c0_ready=1` at `hpos=9`.
  - `stall_cnt=1`.
- Round-robin: both clients valid continuously in vblank. Require grants alternating c0,c1,c0,c1 and `mem_wdata` matching each.
- Vblank gating: `vblank_only=2'b10`, c1 valid from `vpos=100`. Require:
  - `c1_ready=0` until `vpos=480`.
  - Grant at the first `vpos=480` cycle.
- Reset mid-fetch: deassert `rst_n` one cycle after a fetch issue. Require no `pix_valid`, `mem_en=0`, `stall_cnt=0` and `rr`=client 0 after release.
- Saturation: c0 valid with `vblank_only=2'b01` for 300 visible cycles. Require `stall_cnt=255`, and 0 the cycle after `stall_clr`.
